// File: rtl/ex_pkg.sv
// ex_pkg: ALU codes, alu_op encodings and the
// ID/EX control bundle shared by the EX slice.
package ex_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_FUNCT = 2'b10,
    OP_RSVD  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    alu_op_e    alu_op;
    logic [2:0] funct3;
    logic       funct7b5;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_NOP = ex_ctrl_t'('0);

endpackage

// File: rtl/alu_control.sv
// alu_control: maps alu_op/funct bits to one
// of the four ALU operation codes.
import ex_pkg::*;

module alu_control (
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       alu_src,
  output logic [3:0] code
);

  logic is_funct;
  assign is_funct = (alu_op == OP_FUNCT);

  // decode; anything unlisted falls back to ADD
  always_comb begin
    code = ALU_ADD;
    unique case (1'b1)
      alu_op == OP_SUB:
        code = ALU_SUB;
      is_funct && funct3 == 3'b000:
        code = (funct7b5 & ~alu_src) ? ALU_SUB : ALU_ADD;
      is_funct && funct3 == 3'b111:
        code = ALU_AND;
      is_funct && funct3 == 3'b110:
        code = ALU_OR;
      default:
        code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register, ALU decode, forwarding
// and load-use stall. Option: ID_EX_FORWARDING_EN.
import ex_pkg::*;

module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  input  logic            flush,
  input  logic [RW-1:0]   exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RW-1:0]   memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic            stall,
  output logic            ex_valid,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] ex_store_data
);

  ex_ctrl_t        id_ctrl;
  ex_ctrl_t        ctrl_q;
  logic            valid_q;
  logic [RW-1:0]   rd_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic            hazard;
  logic            bubble;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  assign id_ctrl = '{
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    reg_write:  id_reg_write,
    mem_to_reg: id_mem_to_reg,
    branch:     id_branch,
    alu_src:    id_alu_src,
    alu_op:     alu_op_e'(id_alu_op),
    funct3:     id_funct3,
    funct7b5:   id_funct7b5
  };

  logic ex_rd_hit;
  assign ex_rd_hit = (rd_q != '0) &&
                     (rd_q == id_rs1 || rd_q == id_rs2);

`ifdef ID_EX_FORWARDING_EN
  logic [RW-1:0] rs1_q;
  logic [RW-1:0] rs2_q;

  // only a load in EX cannot be forwarded in time
  always_comb begin
    hazard = valid_q & ctrl_q.mem_read & ex_rd_hit;
  end

  // source indices kept for the forwarding compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (bubble) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      rs1_q <= id_rs1;
      rs2_q <= id_rs2;
    end
  end

  // operand forwarding, EX/MEM before MEM/WB, never x0
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exmem_reg_write && exmem_rd != '0 &&
        exmem_rd == rs1_q)
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 &&
             memwb_rd == rs1_q)
      fwd_rs1 = memwb_result;
    fwd_rs2 = rs2_data_q;
    if (exmem_reg_write && exmem_rd != '0 &&
        exmem_rd == rs2_q)
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 &&
             memwb_rd == rs2_q)
      fwd_rs2 = memwb_result;
  end
`else
  logic exmem_hit;
  logic unused_fwd;

  assign exmem_hit = exmem_reg_write &&
                     (exmem_rd != '0) &&
                     (exmem_rd == id_rs1 ||
                      exmem_rd == id_rs2);

  // any RAW on EX or EX/MEM waits for the regfile
  always_comb begin
    hazard = (valid_q & ctrl_q.reg_write & ex_rd_hit) |
             exmem_hit;
  end

  // operands straight from the registered regfile reads
  always_comb begin
    fwd_rs1 = rs1_data_q;
    fwd_rs2 = rs2_data_q;
  end

  assign unused_fwd = ^{memwb_rd, memwb_reg_write,
                        memwb_result, exmem_result};
`endif

  assign stall  = id_valid & hazard & ~flush;
  assign bubble = flush | stall | ~id_valid;

  // ID/EX register: instruction or bubble each edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rd_q       <= '0;
      ctrl_q     <= CTRL_NOP;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (bubble) begin
      valid_q    <= 1'b0;
      rd_q       <= '0;
      ctrl_q     <= CTRL_NOP;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= 1'b1;
      rd_q       <= id_rd;
      ctrl_q     <= id_ctrl;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
    end
  end

  alu_control u_alu_ctrl (
    .alu_op   (ctrl_q.alu_op),
    .funct3   (ctrl_q.funct3),
    .funct7b5 (ctrl_q.funct7b5),
    .alu_src  (ctrl_q.alu_src),
    .code     (alu_control)
  );

  assign alu_rs1       = fwd_rs1;
  assign alu_rs2       = ctrl_q.alu_src ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

  assign ex_valid      = valid_q;
  assign ex_rd         = rd_q;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_branch     = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random + directed stimulus against
// an instruction-level reference model of id_ex_stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_mem_read, id_mem_write;
  logic        id_reg_write, id_mem_to_reg, id_branch;
  logic        flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [63:0] exmem_result, memwb_result;
  logic        stall, ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_mem_to_reg, ex_branch;
  logic [63:0] alu_rs1, alu_rs2, ex_store_data;
  logic [3:0]  alu_control;

  int checks = 0;
  int failures = 0;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_ex_stage #(.XLEN(64), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .flush(flush), .exmem_rd(exmem_rd),
    .exmem_reg_write(exmem_reg_write),
    .exmem_result(exmem_result), .memwb_rd(memwb_rd),
    .memwb_reg_write(memwb_reg_write),
    .memwb_result(memwb_result), .stall(stall),
    .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_control(alu_control), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  // the instruction currently sitting in EX
  typedef struct {
    bit        v;
    bit [4:0]  rd, rs1, rs2;
    bit        mr, mw, rw, m2r, br, src;
    bit [1:0]  op;
    bit [2:0]  f3;
    bit        f7;
    bit [63:0] d1, d2, imm;
  } rec_t;

  rec_t m;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit [3:0] exp_code(rec_t r);
    case (r.op)
      2'd1: return 4'b0110;
      2'd2:
        case (r.f3)
          3'd0: return (r.f7 && !r.src) ? 4'b0110 : 4'b0010;
          3'd7: return 4'b0000;
          3'd6: return 4'b0001;
          default: return 4'b0010;
        endcase
      default: return 4'b0010;
    endcase
  endfunction

  function automatic bit [63:0] exp_val(bit [4:0] idx,
                                        bit [63:0] d);
    if (FWD) begin
      if (exmem_reg_write && exmem_rd != 0 && exmem_rd == idx)
        return exmem_result;
      if (memwb_reg_write && memwb_rd != 0 && memwb_rd == idx)
        return memwb_result;
    end
    return d;
  endfunction

  function automatic bit reads(bit [4:0] r);
    return r != 0 && (r == id_rs1 || r == id_rs2);
  endfunction

  function automatic bit exp_stall();
    bit hz;
    if (FWD)
      hz = m.v && m.mr && reads(m.rd);
    else
      hz = (m.v && m.rw && reads(m.rd)) ||
           (exmem_reg_write && reads(exmem_rd));
    return id_valid && hz && !flush;
  endfunction

  function automatic rec_t next_rec();
    rec_t r = '{default: 0};
    if (id_valid && !flush && !exp_stall()) begin
      r.v = 1; r.rd = id_rd; r.rs1 = id_rs1; r.rs2 = id_rs2;
      r.mr = id_mem_read; r.mw = id_mem_write;
      r.rw = id_reg_write; r.m2r = id_mem_to_reg;
      r.br = id_branch; r.src = id_alu_src;
      r.op = id_alu_op; r.f3 = id_funct3; r.f7 = id_funct7b5;
      r.d1 = id_rs1_data; r.d2 = id_rs2_data; r.imm = id_imm;
    end
    return r;
  endfunction

  task automatic check_all();
    bit [63:0] s2;
    s2 = exp_val(m.rs2, m.d2);
    chk("ex_valid", ex_valid, m.v);
    chk("ex_rd", ex_rd, m.rd);
    chk("ex_ctrl",
        {ex_mem_read, ex_mem_write, ex_reg_write,
         ex_mem_to_reg, ex_branch},
        {m.mr, m.mw, m.rw, m.m2r, m.br});
    chk("alu_control", alu_control, exp_code(m));
    chk("alu_rs1", alu_rs1, exp_val(m.rs1, m.d1));
    chk("alu_rs2", alu_rs2, m.src ? m.imm : s2);
    chk("store_data", ex_store_data, s2);
    chk("stall", stall, exp_stall());
  endtask

  task automatic tick();
    rec_t nxt;
    nxt = next_rec();
    @(posedge clk);
    m = nxt;
    @(negedge clk);
  endtask

  task automatic quiet();
    id_valid = 0; flush = 0;
    exmem_reg_write = 0; memwb_reg_write = 0;
    exmem_rd = 0; memwb_rd = 0;
    exmem_result = 0; memwb_result = 0;
  endtask

  task automatic set_id(input bit [4:0] rs1, rs2, rd,
                        input bit [1:0] op,
                        input bit [2:0] f3,
                        input bit f7, src, mr, mw, rw,
                        input bit [63:0] imm);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_alu_op = op; id_funct3 = f3; id_funct7b5 = f7;
    id_alu_src = src; id_mem_read = mr; id_mem_write = mw;
    id_reg_write = rw; id_mem_to_reg = mr; id_branch = 0;
    id_imm = imm;
    id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom};
  endtask

  task automatic rand_in();
    bit [2:0] f3s [4] = '{3'd0, 3'd6, 3'd7, 3'd3};
    id_valid = ($urandom_range(0, 9) < 8);
    flush = ($urandom_range(0, 9) == 0);
    id_rs1 = $urandom_range(0, 3);
    id_rs2 = $urandom_range(0, 3);
    id_rd = $urandom_range(0, 3);
    id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom};
    id_imm = {$urandom, $urandom};
    id_funct3 = f3s[$urandom_range(0, 3)];
    id_funct7b5 = $urandom;
    id_alu_op = $urandom;
    id_alu_src = $urandom;
    id_mem_read = $urandom;
    id_mem_write = $urandom;
    id_reg_write = $urandom;
    id_mem_to_reg = $urandom;
    id_branch = $urandom;
    exmem_rd = $urandom_range(0, 3);
    exmem_reg_write = $urandom;
    exmem_result = {$urandom, $urandom};
    memwb_rd = $urandom_range(0, 3);
    memwb_reg_write = $urandom;
    memwb_result = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 0;
    set_id(1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet();
    m = '{default: 0};
    @(negedge clk);
    #1;
    check_all();
    chk("rst_alu_control", alu_control, 4'b0010);
    @(negedge clk);
    rst_n = 1;

    // decode: sub, addi with funct7b5, and, or
    set_id(1, 2, 9, 2, 0, 1, 0, 0, 0, 1, 5);
    tick(); #1 check_all();
    chk("dec_sub", alu_control, 4'b0110);
    set_id(1, 2, 9, 2, 0, 1, 1, 0, 0, 1, 5);
    tick(); #1 check_all();
    chk("dec_addi", alu_control, 4'b0010);
    set_id(1, 2, 9, 2, 7, 0, 0, 0, 0, 1, 5);
    tick(); #1 check_all();
    chk("dec_and", alu_control, 4'b0000);
    set_id(1, 2, 9, 2, 6, 0, 0, 0, 0, 1, 5);
    tick(); #1 check_all();
    chk("dec_or", alu_control, 4'b0001);

    // forwarding priority on rs1 = x5
    set_id(5, 6, 10, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    id_valid = 0;
    exmem_rd = 5; exmem_reg_write = 1; exmem_result = 64'hAA;
    memwb_rd = 5; memwb_reg_write = 1; memwb_result = 64'hBB;
    #1 check_all();
    chk("fwd_pri", alu_rs1, FWD ? 64'hAA : m.d1);
    exmem_rd = 0;
    #1 check_all();
    chk("fwd_wb", alu_rs1, FWD ? 64'hBB : m.d1);
    tick();
    quiet();

    // load-use: ld x7 then add x8,x7,x1
    set_id(2, 0, 7, 0, 0, 0, 1, 1, 0, 1, 8);
    tick();
    set_id(7, 1, 8, 2, 0, 0, 0, 0, 0, 1, 0);
    #1 check_all();
    chk("lu_stall", stall, 1'b1);
    tick();
    chk("lu_bubble", ex_valid, 1'b0);
    exmem_rd = 7; exmem_reg_write = 1;
    #1 check_all();
    chk("lu_stall_once", stall, !FWD);
    tick();
    exmem_reg_write = 0;
    memwb_rd = 7; memwb_reg_write = 1; memwb_result = 64'h55;
    #1 check_all();
`ifdef ID_EX_FORWARDING_EN
    chk("lu_fwd", alu_rs1, 64'h55);
`endif
    tick();
    #1 check_all();
    quiet();

    // flush beats stall
    set_id(2, 0, 7, 0, 0, 0, 1, 1, 0, 1, 8);
    tick();
    set_id(7, 1, 8, 2, 0, 0, 0, 0, 0, 1, 0);
    flush = 1;
    #1 check_all();
    chk("fl_stall", stall, 1'b0);
    tick();
    chk("fl_bubble", ex_valid, 1'b0);
    quiet();

    // store: sd x3, 16(x2)
    set_id(2, 3, 0, 0, 0, 0, 1, 0, 1, 0, 16);
    tick();
    id_valid = 0;
    exmem_rd = 3; exmem_reg_write = 1; exmem_result = 64'hCC;
    #1 check_all();
    chk("st_imm", alu_rs2, 64'd16);
    chk("st_data", ex_store_data, FWD ? 64'hCC : m.d2);
    tick();

    // random traffic with an asynchronous reset mid-run
    for (int i = 0; i < 400; i++) begin
      rand_in();
      if (i == 200) begin
        exmem_reg_write = 0;
        memwb_reg_write = 0;
        #3 rst_n = 0;
        m = '{default: 0};
        #1;
        chk("arst_valid", ex_valid, 1'b0);
        chk("arst_alu", alu_control, 4'b0010);
        chk("arst_stall", stall, 1'b0);
        chk("arst_rs1", alu_rs1, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
      end else begin
        #1 check_all();
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
